// File: rtl/ef_pin_mux_glitchless.sv
// Per-pad function multiplexer; every function switch passes through a tri-stated guard window.
// Optional macro EF_PIN_MUX_GLITCHLESS_SYNC_EN inserts a 2-FF synchronizer on io_in.
module ef_pin_mux_glitchless #(
  parameter int unsigned COUNT   = 32,
  parameter int unsigned FUNCS   = 4,
  parameter int unsigned GUARD   = 2,
  parameter logic        IN_IDLE = 1'b1,
  localparam int unsigned SW     = $clog2(FUNCS),
  localparam int unsigned PW     = (COUNT > 1) ? $clog2(COUNT) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [COUNT-1:0]         io_in,
  output logic [COUNT-1:0]         io_out,
  output logic [COUNT-1:0]         io_oeb,
  output logic [COUNT*FUNCS-1:0]   p_in,
  input  logic [COUNT*FUNCS-1:0]   p_out,
  input  logic [COUNT*FUNCS-1:0]   p_oeb,
  input  logic                     cfg_we,
  input  logic [PW-1:0]            cfg_pin,
  input  logic [SW-1:0]            cfg_sel,
  input  logic                     cfg_lock,
  output logic                     cfg_ack,
  output logic                     cfg_err,
  output logic [COUNT*SW-1:0]      sel_rd,
  output logic [COUNT-1:0]         busy
);

  localparam int unsigned CW = $clog2(GUARD + 1);

  typedef enum logic {ST_ACTIVE = 1'b0, ST_GUARD = 1'b1} state_t;

  state_t          r_state     [COUNT];
  logic [SW-1:0]   r_sel       [COUNT];
  logic [SW-1:0]   r_pend      [COUNT];
  logic [CW-1:0]   r_cnt       [COUNT];
  logic [COUNT-1:0] r_lock;
  logic            r_ack;
  logic            r_err;

  state_t          w_state_nxt [COUNT];
  logic [SW-1:0]   w_sel_nxt   [COUNT];
  logic [SW-1:0]   w_pend_nxt  [COUNT];
  logic [CW-1:0]   w_cnt_nxt   [COUNT];
  logic [COUNT-1:0] w_lock_nxt;
  logic            w_acc;
  logic [COUNT-1:0] w_pad_in;

`ifdef EF_PIN_MUX_GLITCHLESS_SYNC_EN
  logic [COUNT-1:0] r_sync1;
  logic [COUNT-1:0] r_sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= {COUNT{IN_IDLE}};
      r_sync2 <= {COUNT{IN_IDLE}};
    end else begin
      r_sync1 <= io_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_pad_in = r_sync2;
`else
  assign w_pad_in = io_in;
`endif

  // State registers for all pins plus the config handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < COUNT; i++) begin
        r_state[i] <= ST_ACTIVE;
        r_sel[i]   <= '0;
        r_pend[i]  <= '0;
        r_cnt[i]   <= '0;
      end
      r_lock <= '0;
      r_ack  <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_pend  <= w_pend_nxt;
      r_cnt   <= w_cnt_nxt;
      r_lock  <= w_lock_nxt;
      r_ack   <= cfg_we;
      r_err   <= cfg_we & ~w_acc;
    end
  end

  // Guard countdown and write acceptance; a busy or locked pin rejects writes
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_pend_nxt  = r_pend;
    w_cnt_nxt   = r_cnt;
    w_lock_nxt  = r_lock;
    w_acc       = 1'b0;
    for (int i = 0; i < COUNT; i++) begin
      if (r_state[i] == ST_GUARD) begin
        w_cnt_nxt[i] = r_cnt[i] - CW'(1);
        if (r_cnt[i] == CW'(1)) begin
          w_state_nxt[i] = ST_ACTIVE;
          w_sel_nxt[i]   = r_pend[i];
        end
      end else if (cfg_we && (cfg_pin == PW'(i)) && !r_lock[i]) begin
        w_acc = 1'b1;
        if (cfg_lock) begin
          w_lock_nxt[i] = 1'b1;
        end
        if (cfg_sel != r_sel[i]) begin
          w_pend_nxt[i]  = cfg_sel;
          w_cnt_nxt[i]   = CW'(GUARD);
          w_state_nxt[i] = ST_GUARD;
        end
      end
    end
  end

  // Combinational pad/peripheral routing
  always_comb begin
    io_out = '0;
    io_oeb = '1;
    p_in   = {(COUNT*FUNCS){IN_IDLE}};
    busy   = '0;
    sel_rd = '0;
    for (int i = 0; i < COUNT; i++) begin
      busy[i]            = (r_state[i] == ST_GUARD);
      sel_rd[i*SW +: SW] = r_sel[i];
      for (int f = 0; f < FUNCS; f++) begin
        if ((r_state[i] == ST_ACTIVE) && (r_sel[i] == SW'(f))) begin
          io_out[i]         = p_out[i*FUNCS + f];
          io_oeb[i]         = p_oeb[i*FUNCS + f];
          p_in[i*FUNCS + f] = w_pad_in[i];
        end
      end
    end
  end

  assign cfg_ack = r_ack;
  assign cfg_err = r_err;

endmodule

// File: tb/tb_ef_pin_mux_glitchless.sv
// Randomized bench for ef_pin_mux_glitchless against a per-pin countdown reference model.
module tb_ef_pin_mux_glitchless;
  localparam int unsigned COUNT = 6;
  localparam int unsigned FUNCS = 4;
  localparam int unsigned GUARD = 2;
  localparam int unsigned SW    = 2;
  localparam int unsigned PW    = 3;
  localparam int unsigned NS    = COUNT * FUNCS;
  localparam logic IN_IDLE      = 1'b1;

  logic clk = 1'b0;
  logic rst;
  logic [COUNT-1:0] io_in, io_out, io_oeb, busy;
  logic [NS-1:0] p_in, p_out, p_oeb;
  logic cfg_we, cfg_lock, cfg_ack, cfg_err;
  logic [PW-1:0] cfg_pin;
  logic [SW-1:0] cfg_sel;
  logic [COUNT*SW-1:0] sel_rd;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: committed sel, pending sel, remaining guard cycles, lock
  int m_sel [COUNT];
  int m_pend[COUNT];
  int m_rem [COUNT];
  bit m_lock[COUNT];
  bit m_ack, m_err;
  logic [COUNT-1:0] m_h1, m_h2;

  always #5 clk = ~clk;

  ef_pin_mux_glitchless #(.COUNT(COUNT), .FUNCS(FUNCS), .GUARD(GUARD), .IN_IDLE(IN_IDLE)) dut (
    .clk(clk), .rst(rst), .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb),
    .p_in(p_in), .p_out(p_out), .p_oeb(p_oeb), .cfg_we(cfg_we), .cfg_pin(cfg_pin),
    .cfg_sel(cfg_sel), .cfg_lock(cfg_lock), .cfg_ack(cfg_ack), .cfg_err(cfg_err),
    .sel_rd(sel_rd), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    bit was_busy[COUNT];
    int p;
    if (rst) begin
      for (int i = 0; i < COUNT; i++) begin
        m_sel[i] = 0; m_pend[i] = 0; m_rem[i] = 0; m_lock[i] = 0;
      end
      m_ack = 0; m_err = 0;
      m_h1 = {COUNT{IN_IDLE}};
      m_h2 = {COUNT{IN_IDLE}};
    end else begin
      m_h2 = m_h1;
      m_h1 = io_in;
      for (int i = 0; i < COUNT; i++) begin
        was_busy[i] = (m_rem[i] > 0);
        if (was_busy[i]) begin
          m_rem[i]--;
          if (m_rem[i] == 0) m_sel[i] = m_pend[i];
        end
      end
      m_ack = cfg_we;
      m_err = 0;
      if (cfg_we) begin
        p = int'(cfg_pin);
        if (p >= COUNT) m_err = 1;
        else if (m_lock[p] || was_busy[p]) m_err = 1;
        else begin
          if (cfg_lock) m_lock[p] = 1;
          if (int'(cfg_sel) != m_sel[p]) begin
            m_pend[p] = int'(cfg_sel);
            m_rem[p]  = GUARD;
          end
        end
      end
    end
  endtask

  task automatic check_all();
    logic [COUNT-1:0] eo, eoeb, eb, pad;
    logic [NS-1:0] ep;
    logic [63:0] es;
`ifdef EF_PIN_MUX_GLITCHLESS_SYNC_EN
    pad = m_h2;
`else
    pad = io_in;
`endif
    es = '0;
    for (int i = 0; i < COUNT; i++) begin
      eb[i] = (m_rem[i] > 0);
      eo[i] = 1'b0;
      eoeb[i] = 1'b1;
      for (int f = 0; f < FUNCS; f++) begin
        ep[i*FUNCS + f] = IN_IDLE;
        if (!eb[i] && f == m_sel[i]) begin
          eo[i] = p_out[i*FUNCS + f];
          eoeb[i] = p_oeb[i*FUNCS + f];
          ep[i*FUNCS + f] = pad[i];
        end
      end
      es = es | (64'(m_sel[i]) << (i * SW));
    end
    chk("io_out", 64'(io_out), 64'(eo));
    chk("io_oeb", 64'(io_oeb), 64'(eoeb));
    chk("p_in",   64'(p_in),   64'(ep));
    chk("busy",   64'(busy),   64'(eb));
    chk("sel_rd", 64'(sel_rd), es);
    chk("ack",    64'(cfg_ack), 64'(m_ack));
    chk("err",    64'(cfg_err), 64'(m_err));
  endtask

  task automatic cyc(input logic we, input int pin, input int sel, input logic lk, input logic r);
    rst = r; cfg_we = we; cfg_pin = PW'(pin); cfg_sel = SW'(sel); cfg_lock = lk;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_pin = '0; cfg_sel = '0; cfg_lock = 1'b0;
    p_out = '1; p_oeb = '0; io_in = COUNT'($urandom);

    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    chk("rst_io_out", 64'(io_out), 64'h3F);
    chk("rst_io_oeb", 64'(io_oeb), 64'h0);
    chk("rst_sel_rd", 64'(sel_rd), 64'h0);
    chk("rst_busy",   64'(busy),   64'h0);

    // Pin 2 -> function 3
    cyc(1, 2, 3, 0, 0);
    chk("p2_ack", 64'(cfg_ack), 64'h1);
    chk("p2_err", 64'(cfg_err), 64'h0);
    chk("p2_busy_t1", 64'(busy[2]), 64'h1);
    chk("p2_oeb_t1", 64'(io_oeb[2]), 64'h1);
    cyc(0, 0, 0, 0, 0);
    chk("p2_busy_t2", 64'(busy[2]), 64'h1);
    cyc(0, 0, 0, 0, 0);
    chk("p2_sel_t3", 64'(sel_rd[5:4]), 64'h3);
    chk("p2_out_t3", 64'(io_out[2]), 64'(p_out[11]));

    // Lock pin 1 at function 2, then try to move it
    cyc(1, 1, 2, 1, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    chk("lock_err", 64'(cfg_err), 64'h1);
    chk("lock_sel", 64'(sel_rd[3:2]), 64'h2);
    cyc(0, 0, 0, 0, 1);
    cyc(1, 1, 3, 0, 0);
    chk("unlock_err", 64'(cfg_err), 64'h0);
    chk("unlock_busy", 64'(busy[1]), 64'h1);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);

    // Back-to-back writes to the same pin
    cyc(1, 0, 1, 0, 0);
    cyc(1, 0, 2, 0, 0);
    chk("b2b_err", 64'(cfg_err), 64'h1);
    cyc(0, 0, 0, 0, 0);
    chk("b2b_busy", 64'(busy[0]), 64'h0);
    chk("b2b_sel", 64'(sel_rd[1:0]), 64'h1);

    // Out-of-range pin
    cyc(1, 7, 1, 0, 0);
    chk("oor_err", 64'(cfg_err), 64'h1);
    chk("oor_busy", 64'(busy), 64'h0);

    // Reset in the middle of a guard window
    cyc(1, 3, 2, 0, 0);
    cyc(0, 0, 0, 0, 1);
    chk("rstg_busy", 64'(busy), 64'h0);
    chk("rstg_sel", 64'(sel_rd), 64'h0);

    // Random traffic
    for (int k = 0; k < 600; k++) begin
      p_out = NS'($urandom);
      p_oeb = NS'($urandom);
      io_in = COUNT'($urandom);
      cyc(logic'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
          logic'($urandom_range(0, 7) == 0), logic'($urandom_range(0, 63) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
